// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell
// and a registered carry. Operands are loaded on an accepted start, one bit
// is processed per clock LSB-first, and the parallel sum/carry-out are
// published together with a one-cycle done strobe.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the registered signed
// overflow output ovf (carry into MSB XOR carry out of MSB).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic               carry;
    logic [CNT_W-1:0]   count;

    logic               s_bit;
    logic               carry_nxt;
    logic               last_bit;
    logic               load;
    logic [WIDTH-1:0]   res_nxt;

    // Full-adder cell on the current LSBs plus control decode.
    always_comb begin
        s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | ((a_sh[0] ^ b_sh[0]) & carry);
        res_nxt   = {s_bit, res_sh[WIDTH-1:1]};
        last_bit  = (count == CNT_W'(WIDTH - 1));
        load      = (state != SHIFT) && start;
    end

    // Next-state logic; start is only honoured outside SHIFT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shifters, carry, bit counter and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (load) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= cin;
            count  <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh <= res_nxt;
            carry  <= carry_nxt;
            count  <= count + 1'b1;
        end
    end

    // Published result: updated only on the edge that processes the MSB,
    // so the final sum bit and carry are taken from the cell directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            sum  <= res_nxt;
            cout <= carry_nxt;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry entering the MSB cell differs from carry leaving it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf <= carry ^ carry_nxt;
        end
    end
`endif

    // Status decoded from the state register only; no input reaches outputs.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against
// a plain-arithmetic reference (a + b + cin), using a WIDTH=8 instance for
// timing/protocol checks and a WIDTH=4 instance for an exhaustive sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
    logic       model_ovf = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_sum  = '0;
    logic       model_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf8),
`endif
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf4),
`endif
        .cout  (cout4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Signed overflow of a + b + cin from operand/result signs.
    function automatic logic sovf8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s);
        return (x[7] == y[7]) && (s[7] != x[7]);
    endfunction

    // One WIDTH=8 addition; optionally pulses start with FF+FF at SHIFT cycle glitch_at.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input int glitch_at);
        logic [8:0] exp;
        int done_k, busy_cnt, hold_bad, overlap;
        exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        done_k = 0; busy_cnt = 0; hold_bad = 0; overlap = 0;
        @(negedge clk);
        start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin
                done_k = k;
                break;
            end
            if (busy8) busy_cnt++;
            if (sum8 !== model_sum || cout8 !== model_cout) hold_bad++;
            if (k == glitch_at) begin
                start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        check("done_latency", done_k, 9);
        check("busy_cycles", busy_cnt, 8);
        check("sum_held_during_shift", hold_bad, 0);
        check("busy_low_with_done", {31'd0, busy8}, 0);
        check("sum", {24'd0, sum8}, {24'd0, exp[7:0]});
        check("cout", {31'd0, cout8}, {31'd0, exp[8]});
        model_sum  = exp[7:0];
        model_cout = exp[8];
`ifdef SERIAL_ADDER_OVF_EN
        model_ovf = sovf8(ta, tb, exp[7:0]);
        check("ovf", {31'd0, ovf8}, {31'd0, model_ovf});
`endif
        @(negedge clk);
        check("done_one_cycle", {31'd0, done8}, 0);
    endtask

    initial begin
        logic [8:0] exp9;
        logic [4:0] exp5;
        logic [7:0] ra, rb;
        logic       rc;
        int         k, dcount;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 0);
        check("rst_done", {31'd0, done8}, 0);
        check("rst_sum", {24'd0, sum8}, 0);
        check("rst_cout", {31'd0, cout8}, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf8}, 0);
`endif
        rst_n = 1'b1;

        // Directed cases, including the overflow boundaries.
        run8(8'h00, 8'h00, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b1, 0);
        run8(8'h7F, 8'h01, 1'b0, 0);
        run8(8'h80, 8'h80, 1'b0, 0);
        run8(8'hFF, 8'hFF, 1'b1, 0);
        // start during SHIFT must be ignored.
        run8(8'h12, 8'h34, 1'b0, 3);

        // Randomized operands.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run8(ra, rb, rc, (i % 3 == 0) ? int'($urandom_range(1, 8)) : 0);
        end

        // Back-to-back with start held high; operands change in each DONE cycle.
        @(negedge clk);
        start8 = 1'b1;
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        a8 = ra; b8 = rb; cin8 = rc;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            k = 1;
            while (!done8 && k < 20) begin
                @(negedge clk);
                k++;
            end
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            check("b2b_latency", k, 9);
            check("b2b_sum", {23'd0, cout8, sum8}, {23'd0, exp9});
            model_sum = exp9[7:0]; model_cout = exp9[8];
`ifdef SERIAL_ADDER_OVF_EN
            model_ovf = sovf8(ra, rb, exp9[7:0]);
            check("b2b_ovf", {31'd0, ovf8}, {31'd0, model_ovf});
`endif
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a8 = ra; b8 = rb; cin8 = rc;
        end
        start8 = 1'b0;
        @(negedge clk);

        // Reset in the middle of SHIFT discards the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy8}, 0);
        check("midrst_done", {31'd0, done8}, 0);
        check("midrst_sum", {24'd0, sum8}, 0);
        check("midrst_cout", {31'd0, cout8}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_sum = '0; model_cout = 1'b0;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        check("no_done_after_reset", dcount, 0);
        run8(8'h01, 8'h01, 1'b0, 0);

        // Exhaustive sweep of the WIDTH=4 instance.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    start4 = 1'b1; a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c);
                    @(negedge clk);
                    start4 = 1'b0;
                    k = 1;
                    while (!done4 && k < 12) begin
                        @(negedge clk);
                        k++;
                    end
                    exp5 = 5'(x + y + c);
                    check("w4_latency", k, 5);
                    check("w4_sum", {27'd0, cout4, sum4}, {27'd0, exp5});
`ifdef SERIAL_ADDER_OVF_EN
                    check("w4_ovf", {31'd0, ovf4},
                          {31'd0, (a4[3] == b4[3]) && (exp5[3] != a4[3])});
`endif
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell and a registered carry. Replaces a ripple-carry chain wherever area matters more than latency. Accepts a start pulse with parallel operands, processes one bit per clock LSB-first, and presents the parallel sum and carry-out with a one-cycle done strobe. Sits downstream of operand registers and upstream of any consumer that reads a completed sum.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  load request; accepted only when busy=0
- a  input  WIDTH  operand A, sampled on the accepting edge
- b  input  WIDTH  operand B, sampled on the accepting edge
- cin  input  1  carry-in, sampled on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle strobe: sum/cout just updated
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out, held with sum
- ovf  output  1  signed overflow (present only with SERIAL_ADDER_OVF_EN)

One clock (clk). Reset rst_n is asynchronous and active-low.

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and bit counter cleared.
- IDLE/DONE + start=1: load a, b into shift registers, carry←cin, count←0, go to SHIFT. start=0: DONE→IDLE, IDLE stays.
- SHIFT, each edge: s_bit=a0^b0^c; c←(a0&b0)|((a0^b0)&c); s_bit shifts into result register from MSB side; operands shift right; count++. On the edge where count reaches WIDTH-1: copy result to sum, carry to cout, go to DONE.
- start while in SHIFT ignored; operands unchanged.
- DONE lasts one cycle (done=1) and accepts start, enabling back-to-back additions.
- sum/cout change only on the completion edge; the previous result stays visible throughout SHIFT.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- rst_n low at any time, mid-operation included: immediate return to reset values; the partial result is discarded and no done is issued.

## Timing
- Accepting edge E0. busy=1 after E0 through edge E(WIDTH), done=1 after E(WIDTH) for exactly one cycle; busy and done never high together.
- Latency start→done: WIDTH+1 edges. Throughput: one addition per WIDTH+1 cycles with start held or re-pulsed in DONE.
- sum, cout, ovf update together on E(WIDTH).
- All outputs registered; no combinational path from input to output.

## Configuration
- SERIAL_ADDER_OVF_EN defined: port ovf exists; ovf = (carry into MSB) XOR (carry out of MSB), captured on the completion edge, held with sum, reset to 0.
- Undefined: no ovf port and no MSB-carry register; all other behaviour identical.

## Test plan
- WIDTH=8, reset released, start with a=8'h00, b=8'h00, cin=0 → done exactly 9 edges after accept; sum=8'h00, cout=0; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1; a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1.
- Start 8'h12+8'h34, pulse start with 8'hFF+8'hFF at cycle 3 of SHIFT → ignored; result sum=8'h46, cout=0; sum holds the previous value until completion.
- start held high continuously, operands changed each DONE cycle → back-to-back results every 9 cycles, each correct; exhaustive sweep with WIDTH=4 against a+b+cin.
- rst_n low at SHIFT cycle 4 → busy, done, sum, cout = 0 immediately; no done afterwards; a following start with 8'h01+8'h01 gives 8'h02.
- With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 → sum=8'h80, ovf=1, cout=0; 8'h80+8'h80 → sum=8'h00, ovf=1, cout=1; 8'hFF+8'h01 → ovf=0.
